// File: rtl/generic_bus_arbiter.sv
`timescale 1ns/1ps
// generic_bus_arbiter
// Shares one downstream GenericBus among NumMgrs managers. Arbitration is
// round-robin and the grant is registered. A grant is held for a whole
// transaction, which is either a single beat or every beat of a burst. One
// IDLE cycle always separates two grants.
// Build option GENERIC_BUS_ARB_FIXED_PRIO_EN: the lowest index always wins,
// and there is no round-robin pointer. All timing stays the same.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no owner, s* driven 0; winner picked, owns from next cycle
// ST_OWNED | grant one-hot; s* muxed from owner; count beats until release

module generic_bus_arbiter #(
  parameter int NumMgrs       = 2,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int BurstLenWidth = 8
) (
  input  logic                                clk,
  input  logic                                nReset,
  input  logic [NumMgrs*AddrWidth-1:0]        mAddr,
  input  logic [NumMgrs*DataWidth-1:0]        mWData,
  input  logic [NumMgrs*(DataWidth/8)-1:0]    mWStrb,
  input  logic [NumMgrs-1:0]                  mWEn,
  input  logic [NumMgrs-1:0]                  mREn,
  input  logic [NumMgrs-1:0]                  mIsBurst,
  input  logic [NumMgrs-1:0]                  mNonSec,
  input  logic [NumMgrs*2-1:0]                mBurstType,
  input  logic [NumMgrs*BurstLenWidth-1:0]    mBurstLen,
  input  logic [NumMgrs*3-1:0]                mProt,
  output logic [NumMgrs*DataWidth-1:0]        mRData,
  output logic [NumMgrs-1:0]                  mError,
  output logic [NumMgrs-1:0]                  mBusy,
  output logic [AddrWidth-1:0]                sAddr,
  output logic [DataWidth-1:0]                sWData,
  output logic [DataWidth/8-1:0]              sWStrb,
  output logic                                sWEn,
  output logic                                sREn,
  output logic                                sIsBurst,
  output logic [1:0]                          sBurstType,
  output logic [BurstLenWidth-1:0]            sBurstLen,
  output logic                                sNonSec,
  output logic [2:0]                          sProt,
  input  logic [DataWidth-1:0]                sRData,
  input  logic                                sError,
  input  logic                                sBusy,
  output logic [NumMgrs-1:0]                  grant
);

  localparam int StrbWidth = DataWidth / 8;
  localparam int IdxWidth  = (NumMgrs > 1) ? $clog2(NumMgrs) : 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;

  logic [0:0]               state;
  logic [IdxWidth-1:0]      owner;
  logic [BurstLenWidth-1:0] beat_cnt;
  logic [NumMgrs-1:0]       req;
  logic [IdxWidth-1:0]      search_base;
  logic                     win_found;
  logic [IdxWidth-1:0]      win_idx;
  int                       cand;
  int                       owner_i;
  logic                     own_req;
  logic                     own_burst;
  logic [BurstLenWidth-1:0] own_len;
  logic                     beat_done;
  logic                     owner_release;

  assign req     = mWEn | mREn;
  assign owner_i = int'(owner);

`ifdef GENERIC_BUS_ARB_FIXED_PRIO_EN
  // Fixed priority: the search always starts at manager 0
  assign search_base = '0;
`else
  logic [IdxWidth-1:0] rr_ptr;
  logic [IdxWidth-1:0] next_ptr;

  // Pointer moves to the manager after the releasing owner. NumMgrs need not
  // be a power of two, so the wrap is explicit.
  always_comb begin
    if (owner_i == NumMgrs - 1) next_ptr = '0;
    else                        next_ptr = owner + IdxWidth'(1);
  end

  // Round-robin pointer advances only on release
  always_ff @(posedge clk) begin
    if (!nReset)            rr_ptr <= '0;
    else if (owner_release) rr_ptr <= next_ptr;
  end

  assign search_base = rr_ptr;
`endif

  // First requester at or after search_base, searching upward with wrap
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NumMgrs; k++) begin
      cand = int'(search_base) + k;
      if (cand >= NumMgrs) cand = cand - NumMgrs;
      if (!win_found && req[IdxWidth'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IdxWidth'(cand);
      end
    end
  end

  // Burst fields are sampled from the owner every beat, not latched at grant
  assign own_req   = req[owner];
  assign own_burst = mIsBurst[owner];
  assign own_len   = mBurstLen[owner_i*BurstLenWidth +: BurstLenWidth];

  assign beat_done     = (state == ST_OWNED) && own_req && !sBusy;
  assign owner_release = (state == ST_OWNED) &&
                         (!own_req ||
                          (beat_done && (!own_burst || (beat_cnt == own_len))));

  // Grant FSM: IDLE picks a winner, OWNED holds until the transaction ends
  always_ff @(posedge clk) begin
    if (!nReset) begin
      state    <= ST_IDLE;
      grant    <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            state    <= ST_OWNED;
            grant    <= NumMgrs'(1) << win_idx;
            owner    <= win_idx;
            beat_cnt <= '0;
          end
        end
        ST_OWNED: begin
          if (owner_release) begin
            state    <= ST_IDLE;
            grant    <= '0;
            beat_cnt <= '0;
          end else if (beat_done) begin
            beat_cnt <= beat_cnt + BurstLenWidth'(1);
          end
        end
      endcase
    end
  end

  // Request mux downstream and response fan-out upstream. Non-owners see busy
  // while they request, so they hold their request.
  always_comb begin
    sAddr      = '0;
    sWData     = '0;
    sWStrb     = '0;
    sWEn       = 1'b0;
    sREn       = 1'b0;
    sIsBurst   = 1'b0;
    sBurstType = '0;
    sBurstLen  = '0;
    sNonSec    = 1'b0;
    sProt      = '0;
    mRData     = '0;
    mError     = '0;
    mBusy      = req;
    if (state == ST_OWNED) begin
      sAddr      = mAddr[owner_i*AddrWidth +: AddrWidth];
      sWData     = mWData[owner_i*DataWidth +: DataWidth];
      sWStrb     = mWStrb[owner_i*StrbWidth +: StrbWidth];
      sWEn       = mWEn[owner];
      sREn       = mREn[owner];
      sIsBurst   = mIsBurst[owner];
      sBurstType = mBurstType[owner_i*2 +: 2];
      sBurstLen  = own_len;
      sNonSec    = mNonSec[owner];
      sProt      = mProt[owner_i*3 +: 3];
      mRData[owner_i*DataWidth +: DataWidth] = sRData;
      mError[owner] = sError;
      mBusy[owner]  = sBusy;
    end
  end

endmodule

// File: tb/tb_generic_bus_arbiter.sv
`timescale 1ns/1ps
// Bench for generic_bus_arbiter: directed scenarios plus random traffic,
// all compared each cycle against a transaction-level reference model.

module tb_generic_bus_arbiter;

  localparam int N   = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int BLW = 8;
  localparam int SBW = AW + DW + SW + 1 + 1 + 1 + 2 + BLW + 1 + 3;

  logic            clk = 1'b0;
  logic            nReset;
  logic [N*AW-1:0] mAddr;
  logic [N*DW-1:0] mWData;
  logic [N*SW-1:0] mWStrb;
  logic [N-1:0]    mWEn, mREn, mIsBurst, mNonSec;
  logic [N*2-1:0]  mBurstType;
  logic [N*BLW-1:0] mBurstLen;
  logic [N*3-1:0]  mProt;
  logic [N*DW-1:0] mRData;
  logic [N-1:0]    mError, mBusy;
  logic [AW-1:0]   sAddr;
  logic [DW-1:0]   sWData;
  logic [SW-1:0]   sWStrb;
  logic            sWEn, sREn, sIsBurst, sNonSec;
  logic [1:0]      sBurstType;
  logic [BLW-1:0]  sBurstLen;
  logic [2:0]      sProt;
  logic [DW-1:0]   sRData;
  logic            sError, sBusy;
  logic [N-1:0]    grant;

  int n_chk = 0;
  int n_err = 0;

  // reference model: current owner (-1 = none), pointer, beats done
  int mo = -1;
  int mp = 0;
  int mc = 0;

  always #5 clk = ~clk;

  generic_bus_arbiter #(
    .NumMgrs(N), .AddrWidth(AW), .DataWidth(DW), .BurstLenWidth(BLW)
  ) dut (
    .clk(clk), .nReset(nReset),
    .mAddr(mAddr), .mWData(mWData), .mWStrb(mWStrb),
    .mWEn(mWEn), .mREn(mREn), .mIsBurst(mIsBurst), .mNonSec(mNonSec),
    .mBurstType(mBurstType), .mBurstLen(mBurstLen), .mProt(mProt),
    .mRData(mRData), .mError(mError), .mBusy(mBusy),
    .sAddr(sAddr), .sWData(sWData), .sWStrb(sWStrb), .sWEn(sWEn),
    .sREn(sREn), .sIsBurst(sIsBurst), .sBurstType(sBurstType),
    .sBurstLen(sBurstLen), .sNonSec(sNonSec), .sProt(sProt),
    .sRData(sRData), .sError(sError), .sBusy(sBusy), .grant(grant)
  );

  task automatic check_val(input string tag, input logic [127:0] obs,
                           input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    mAddr = '0; mWData = '0; mWStrb = '0; mWEn = '0; mREn = '0;
    mIsBurst = '0; mNonSec = '0; mBurstType = '0; mBurstLen = '0; mProt = '0;
    sRData = '0; sError = 1'b0; sBusy = 1'b0;
  endtask

  // One clock: check outputs against the model, advance the model, reach
  // the next falling edge. Inputs for this cycle must already be applied.
  task automatic cycle();
    logic [N-1:0]    req;
    logic [N-1:0]    e_grant, e_err, e_busy;
    logic [N*DW-1:0] e_rdata;
    logic [SBW-1:0]  e_s, o_s;
    int base;
    int c;
    bit last;
    #1;
    req     = mWEn | mREn;
    e_grant = '0;
    e_err   = '0;
    e_busy  = req;
    e_rdata = '0;
    e_s     = '0;
    if (mo >= 0) begin
      e_grant = N'(1) << mo;
      e_s = {mAddr[mo*AW +: AW], mWData[mo*DW +: DW], mWStrb[mo*SW +: SW],
             mWEn[mo +: 1], mREn[mo +: 1], mIsBurst[mo +: 1],
             mBurstType[mo*2 +: 2], mBurstLen[mo*BLW +: BLW],
             mNonSec[mo +: 1], mProt[mo*3 +: 3]};
      e_rdata[mo*DW +: DW] = sRData;
      e_err[mo +: 1]  = sError;
      e_busy[mo +: 1] = sBusy;
    end
    o_s = {sAddr, sWData, sWStrb, sWEn, sREn, sIsBurst, sBurstType,
           sBurstLen, sNonSec, sProt};
    check_val("grant",   128'(grant),  128'(e_grant));
    check_val("s_bus",   128'(o_s),    128'(e_s));
    check_val("m_rdata", 128'(mRData), 128'(e_rdata));
    check_val("m_error", 128'(mError), 128'(e_err));
    check_val("m_busy",  128'(mBusy),  128'(e_busy));

    if (!nReset) begin
      mo = -1; mp = 0; mc = 0;
    end else if (mo < 0) begin
`ifdef GENERIC_BUS_ARB_FIXED_PRIO_EN
      base = 0;
`else
      base = mp;
`endif
      for (int k = 0; k < N; k++) begin
        c = (base + k) % N;
        if (mo < 0 && req[c +: 1] == 1'b1) begin
          mo = c;
          mc = 0;
        end
      end
    end else if (req[mo +: 1] == 1'b0) begin
      mp = (mo + 1) % N;
      mo = -1;
    end else if (!sBusy) begin
      last = (mIsBurst[mo +: 1] == 1'b0) || (mc == int'(mBurstLen[mo*BLW +: BLW]));
      if (last) begin
        mp = (mo + 1) % N;
        mo = -1;
      end else begin
        mc++;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    nReset = 1'b0;
    cycle();
    cycle();
    nReset = 1'b1;
  endtask

  task automatic rand_mgr(input int i);
    int r;
    r = int'($urandom_range(0, 3));
    mWEn[i +: 1] = (r == 1 || r == 3) ? 1'b1 : 1'b0;
    mREn[i +: 1] = (r == 2) ? 1'b1 : 1'b0;
    mAddr[i*AW +: AW]      = AW'($urandom());
    mWData[i*DW +: DW]     = DW'($urandom());
    mWStrb[i*SW +: SW]     = SW'($urandom());
    mIsBurst[i +: 1]       = 1'($urandom());
    mBurstType[i*2 +: 2]   = 2'($urandom());
    mBurstLen[i*BLW +: BLW] = BLW'($urandom_range(0, 3));
    mNonSec[i +: 1]        = 1'($urandom());
    mProt[i*3 +: 3]        = 3'($urandom());
  endtask

  logic [N-1:0] exp_seq [8];
  logic [N-1:0] exp_burst [7];
  int beats0, beats1;
  bit seen;

  initial begin
    // reset held two cycles while both managers write
    clear_inputs();
    mWEn   = 2'b11;
    nReset = 1'b0;
    @(negedge clk);
    mo = -1; mp = 0; mc = 0;
    #1;
    check_val("rst_grant", 128'(grant), 128'(0));
    check_val("rst_swen",  128'(sWEn),  128'(0));
    check_val("rst_busy",  128'(mBusy), 128'(2'b11));
    cycle();
    nReset = 1'b1;
    cycle();
    check_val("rst_first_grant", 128'(grant), 128'(2'b01));
    cycle();

    // single write from manager 1
    do_reset();
    mWEn[1] = 1'b1;
    mAddr[AW +: AW]  = 32'h0000_0100;
    mWData[DW +: DW] = 32'hDEAD_BEEF;
    cycle();
    #1;
    check_val("wr_saddr", 128'(sAddr),  128'(32'h100));
    check_val("wr_wdata", 128'(sWData), 128'(32'hDEADBEEF));
    check_val("wr_grant", 128'(grant),  128'(2'b10));
    cycle();
    check_val("wr_release", 128'(grant), 128'(0));
    mWEn = 2'b11;
    cycle();
    check_val("wr_ptr_back_to_0", 128'(grant), 128'(2'b01));
    clear_inputs();
    cycle();
    cycle();

    // fairness with continuous single beats
`ifdef GENERIC_BUS_ARB_FIXED_PRIO_EN
    exp_seq = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01};
`else
    exp_seq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
`endif
    do_reset();
    mWEn = 2'b11;
    beats0 = 0;
    beats1 = 0;
    for (int k = 0; k < 8; k++) begin
      check_val($sformatf("rr_grant_%0d", k), 128'(grant), 128'(exp_seq[k]));
      if (grant[0]) beats0++;
      if (grant[1]) beats1++;
      cycle();
    end
`ifdef GENERIC_BUS_ARB_FIXED_PRIO_EN
    check_val("rr_beats_m0", 128'(beats0), 128'(4));
    check_val("rr_beats_m1", 128'(beats1), 128'(0));
`else
    check_val("rr_beats_m0", 128'(beats0), 128'(2));
    check_val("rr_beats_m1", 128'(beats1), 128'(2));
`endif

    // burst lock: manager 0 four beats while manager 1 waits
`ifdef GENERIC_BUS_ARB_FIXED_PRIO_EN
    exp_burst = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01};
`else
    exp_burst = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10};
`endif
    do_reset();
    mWEn = 2'b11;
    mIsBurst[0] = 1'b1;
    mBurstLen[0 +: BLW] = 8'd3;
    for (int k = 0; k < 7; k++) begin
      check_val($sformatf("burst_grant_%0d", k), 128'(grant), 128'(exp_burst[k]));
      cycle();
    end

    // busy stall then an error response on a read
    do_reset();
    mREn[0] = 1'b1;
    cycle();
    for (int k = 0; k < 3; k++) begin
      sBusy = 1'b1;
      #1;
      check_val($sformatf("stall_busy_%0d", k), 128'(mBusy[0]), 128'(1));
      cycle();
    end
    sBusy  = 1'b0;
    sError = 1'b1;
    sRData = 32'h5A5A_5A5A;
    #1;
    check_val("err_grant",   128'(grant),  128'(2'b01));
    check_val("err_flags",   128'(mError), 128'(2'b01));
    check_val("err_rdata0",  128'(mRData[DW-1:0]), 128'(32'h5A5A5A5A));
    check_val("err_rdata1",  128'(mRData[2*DW-1:DW]), 128'(0));
    check_val("err_busy",    128'(mBusy[0]), 128'(0));
    cycle();
    check_val("err_release", 128'(grant), 128'(0));
    clear_inputs();
    cycle();

`ifdef GENERIC_BUS_ARB_FIXED_PRIO_EN
    // manager 0 wins every grant until it stops requesting
    do_reset();
    mWEn = 2'b11;
    for (int k = 0; k < 8; k++) begin
      if (grant != 2'b00) check_val("fp_owner", 128'(grant), 128'(2'b01));
      cycle();
    end
    mWEn[0] = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (grant == 2'b10) seen = 1'b1;
      cycle();
    end
    check_val("fp_m1_granted", 128'(seen), 128'(1));
`endif

    // random traffic
    do_reset();
    for (int t = 0; t < 4000; t++) begin
      nReset = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      for (int i = 0; i < N; i++) begin
        if (i == mo) begin
          mWData[i*DW +: DW] = DW'($urandom());
          if ($urandom_range(0, 39) == 0) begin
            mWEn[i +: 1] = 1'b0;
            mREn[i +: 1] = 1'b0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          rand_mgr(i);
        end
      end
      sBusy  = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      sError = 1'($urandom());
      sRData = DW'($urandom());
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/generic_bus_arbiter.md
Name: generic_bus_arbiter

Overview:
- Shares one downstream GenericBus between NumMgrs upstream managers; each manager presents a flattened GenericBus manager port.
- Round-robin arbitration with a registered grant. The grant is held for a whole transaction: a single beat, or all beats of a burst.
- Sits between CPU/DMA-style managers and the address-decoding subordinate fabric.

Parameters:
- NumMgrs, 2, number of upstream managers (2..8).
- AddrWidth, 32, address width.
- DataWidth, 32, data width; strobe width is DataWidth/8.
- BurstLenWidth, 8, width of burstLen.

Ports:
- clk  in  1  clock.
- nReset  in  1  synchronous active-low reset.
- mAddr  in  NumMgrs*AddrWidth  per-manager addr; manager i occupies slice i.
- mWData  in  NumMgrs*DataWidth  per-manager wData.
- mWStrb  in  NumMgrs*DataWidth/8  per-manager wStrb.
- mWEn, mREn, mIsBurst, mNonSec  in  NumMgrs  per-manager controls.
- mBurstType  in  NumMgrs*2  per-manager burstType.
- mBurstLen  in  NumMgrs*BurstLenWidth  per-manager burstLen (beats minus 1).
- mProt  in  NumMgrs*3  per-manager prot.
- mRData  out  NumMgrs*DataWidth  rData returned to managers.
- mError, mBusy  out  NumMgrs  per-manager error and busy.
- sAddr, sWData, sWStrb, sWEn, sREn, sIsBurst, sBurstType, sBurstLen, sNonSec, sProt  out  (matching widths)  downstream bus request.
- sRData  in  DataWidth  downstream rData.
- sError, sBusy  in  1  downstream error and busy.
- grant  out  NumMgrs  one-hot current owner; all zero when idle.

Behaviour:
- Clock and reset: single clock clk; reset nReset is synchronous, active-low.
- Request definition: req[i] = mWEn[i] | mREn[i].
- Reset values:
  - state=IDLE, grant=0, rrPtr=0, beatCnt=0.
  - All s* request outputs are 0.
  - mBusy = req (every requester sees busy), mError=0, mRData=0.
- IDLE state:
  - s* request outputs are driven 0.
  - If any req is set, choose the first requester at or after rrPtr, searching upward with wrap.
  - Next cycle: grant becomes one-hot to that winner, state=OWNED, beatCnt=0.
  - Arbitration latency is exactly 1 cycle. A lone requester whose request rises in cycle N is forwarded downstream in cycle N+1.
- OWNED state:
  - All s* request outputs mux from the granted manager, combinationally.
  - The owner's mRData/mError/mBusy = sRData/sError/sBusy.
  - Non-owners get mBusy=req[i], mError=0, mRData=0.
- Beat completion: a beat completes in a cycle where the owner's req=1 and sBusy=0.
  - Each completed beat increments beatCnt.
- Release: grant drops at the next edge, and the block returns to IDLE with rrPtr=(owner+1) mod NumMgrs, when any of the following holds:
  - a beat completes and the owner's mIsBurst=0;
  - a beat completes and beatCnt==mBurstLen of the owner (the final beat of burstLen+1 beats);
  - the owner's req=0 (abandon; counts no beat).
- Idle bubble: one IDLE cycle always separates consecutive grants. Back-to-back throughput is therefore one beat per 2 cycles across owner changes.
- Burst parameters are sampled combinationally each beat. Managers must hold isBurst/burstLen stable for the whole burst; behaviour is undefined otherwise.
- sError=1 on a completed beat: the error is passed to the owner, and the beat counts normally. A burst is not aborted by the arbiter.
- Downstream busy: sBusy=1 holds the grant indefinitely, with no timeout.
- Simultaneous release and new requests: the release edge always goes to IDLE. The new winner is chosen in the IDLE cycle using the updated rrPtr.
- Reset mid-transaction: everything returns to reset values at the next edge. The outstanding beat is dropped without notification.
- Pointer wrap: rrPtr wraps at NumMgrs (not a power of 2 in general); the comparison uses a modulo increment.

Optional Feature:
- Macro GENERIC_BUS_ARB_FIXED_PRIO_EN.
- Defined:
  - Arbitration is fixed priority; the lowest index wins.
  - rrPtr is not implemented and is treated as 0.
  - All other timing is unchanged.
- Undefined: round-robin as described above.

Test Plan:
- Reset: nReset=0 for 2 cycles while mWEn=2'b11 -> grant=0, sWEn=0, mBusy=2'b11; after release, grant=2'b01 one cycle later.
- Single write: manager 1 drives wEn, addr=0x100, wData=0xDEADBEEF, and sBusy=0 -> sAddr=0x100 in the cycle after the request. Grant drops after 1 beat, then rrPtr=0.
- Round-robin fairness: both managers request continuously with single beats and sBusy=0 -> grant sequence 01,00,10,00,01,...; each manager completes 1 beat per 4 cycles.
- Burst lock: manager 0 runs isBurst=1, burstLen=3, while manager 1 requests throughout -> manager 0 keeps the grant for 4 completed beats. Manager 1 is granted 2 cycles after the 4th beat completes.
- Busy stall and error: owner read with sBusy=1 for 3 cycles, then sBusy=0, sError=1, sRData=0x5A5A5A5A -> the owner sees busy for 3 cycles, then error=1 and rData=0x5A5A5A5A. The non-owner sees error=0.
- Fixed priority (macro defined): both managers request continuously -> manager 0 receives every grant; manager 1 is granted only after manager 0 deasserts.
